// File: rtl/rnf_txrsp_if.sv
// CHI RSP-channel bundle between the RN-F protocol layer, the TXRSP link stage
// and the HN-F RXRSP receiver.
interface rnf_txrsp_if #(
    parameter int unsigned FLIT_W = 53
);
    logic              link_en;
    logic              link_active;
    logic [FLIT_W-1:0] txrsp_in;
    logic              txrsp_in_valid;
    logic              txrsp_in_ready;
    logic [FLIT_W-1:0] TXRSPFLIT;
    logic              TXRSPFLITV;
    logic              TXRSPFLITPEND;
    logic              TXRSPLCRDV;
    logic [3:0]        lcrd_cnt;
    logic              lcrd_overflow;

    modport slave (
        input  link_en, txrsp_in, txrsp_in_valid, TXRSPLCRDV,
        output link_active, txrsp_in_ready, TXRSPFLIT, TXRSPFLITV,
               TXRSPFLITPEND, lcrd_cnt, lcrd_overflow
    );

    modport master (
        output link_en, txrsp_in, txrsp_in_valid, TXRSPLCRDV,
        input  link_active, txrsp_in_ready, TXRSPFLIT, TXRSPFLITV,
               TXRSPFLITPEND, lcrd_cnt, lcrd_overflow
    );
endinterface

// File: rtl/rnf_txrsp.sv
// RN-F TXRSP link-layer stage: L-credit tracking, flit launch and the
// STOP/RUN/DEACT link sequence with LCrdReturn of unused credits.
module rnf_txrsp #(
    parameter int unsigned MAX_LCRD = 15,
    parameter logic [6:0]  SRC_ID   = 7'd0,
    parameter logic [6:0]  TGT_ID   = 7'd0
) (
    input  logic          clock,
    input  logic          reset,
    rnf_txrsp_if.slave    bus
);

    typedef struct packed {
        logic [3:0] qos;
        logic [6:0] tgt_id;
        logic [6:0] src_id;
        logic [7:0] txn_id;
        logic [5:0] opcode;
        logic [1:0] resp_err;
        logic [2:0] resp;
        logic [2:0] fwd_state;
        logic [7:0] dbid;
        logic [3:0] pcrd_type;
        logic       trace_tag;
    } rspflit_t;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DEACT = 2'd2
    } state_e;

    localparam logic [3:0] MAX_CNT      = 4'(MAX_LCRD);
    localparam logic [5:0] OP_LCRDRETURN = 6'h00;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       ovf_q, ovf_d;
    logic       flitv_q, flitv_d;
    rspflit_t   flit_q, flit_d;

    rspflit_t   in_flit;
    rspflit_t   ret_flit;
    logic       issue_ok;
    logic       issue;
    logic       ready;
    logic [4:0] cnt_sum;

    assign in_flit = bus.txrsp_in;

    always_comb begin
        ret_flit        = '0;
        ret_flit.opcode = OP_LCRDRETURN;
        ret_flit.src_id = SRC_ID;
        ret_flit.tgt_id = TGT_ID;
    end

    // Both terms are registered, so a credit granted this cycle is usable next cycle.
    assign issue_ok = pend_q && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        issue   = 1'b0;
        flit_d  = flit_q;

        case (state_q)
            STOP: begin
                if (bus.link_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = issue_ok;
                if (bus.txrsp_in_valid && issue_ok) begin
                    issue  = 1'b1;
                    flit_d = in_flit;
                end
                if (!bus.link_en) begin
                    state_d = DEACT;
                end
            end
            DEACT: begin
                if (issue_ok) begin
                    issue  = 1'b1;
                    flit_d = ret_flit;
                end
                if ((cnt_q == '0) && !bus.TXRSPLCRDV && !issue) begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase

        pend_d  = (state_d != STOP);
        flitv_d = issue;

        cnt_sum = {1'b0, cnt_q} + {4'b0, bus.TXRSPLCRDV} - {4'b0, issue};
        if (cnt_sum > {1'b0, MAX_CNT}) begin
            cnt_d = MAX_CNT;
        end else begin
            cnt_d = cnt_sum[3:0];
        end

        ovf_d = ovf_q || (bus.TXRSPLCRDV && (cnt_q == MAX_CNT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= STOP;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            flitv_q <= flitv_d;
            flit_q  <= flit_d;
        end
    end

    assign bus.link_active    = (state_q == RUN);
    assign bus.txrsp_in_ready = ready;
    assign bus.TXRSPFLIT      = flit_q;
    assign bus.TXRSPFLITV     = flitv_q;
    assign bus.TXRSPFLITPEND  = pend_q;
    assign bus.lcrd_cnt       = cnt_q;
    assign bus.lcrd_overflow  = ovf_q;

endmodule

// File: tb/tb_rnf_txrsp.sv
// Directed bench for rnf_txrsp: per-cycle vector table plus hand-written
// deactivation-with-grant and mid-stream reset sequences.
module tb_rnf_txrsp;

    localparam logic [6:0] SRC = 7'h2A;
    localparam logic [6:0] TGT = 7'h13;

    typedef struct packed {
        logic [3:0] qos;
        logic [6:0] tgt_id;
        logic [6:0] src_id;
        logic [7:0] txn_id;
        logic [5:0] opcode;
        logic [1:0] resp_err;
        logic [2:0] resp;
        logic [2:0] fwd_state;
        logic [7:0] dbid;
        logic [3:0] pcrd_type;
        logic       trace_tag;
    } flit_t;

    typedef struct {
        logic       en;
        logic       val;
        logic       lcrdv;
        logic [7:0] txn;
        logic       act;
        logic       rdy;
        logic       v;
        logic       pend;
        logic       ovf;
        logic [3:0] cnt;
        logic       ret;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic prev_pend;
    vec_t vecs[$];

    rnf_txrsp_if #(.FLIT_W(53)) bus ();

    rnf_txrsp #(
        .MAX_LCRD (15),
        .SRC_ID   (SRC),
        .TGT_ID   (TGT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk_data(input logic [7:0] txn);
        flit_t f;
        f           = '0;
        f.qos       = 4'h3;
        f.tgt_id    = 7'h21;
        f.src_id    = 7'h05;
        f.txn_id    = txn;
        f.opcode    = 6'h14;
        f.resp      = 3'b010;
        f.dbid      = 8'hA5;
        f.trace_tag = 1'b1;
        return f;
    endfunction

    function automatic flit_t mk_ret();
        flit_t f;
        f        = '0;
        f.src_id = SRC;
        f.tgt_id = TGT;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic val, input logic lcrdv, input logic [7:0] txn,
                       input logic act, input logic rdy, input logic v, input logic pend,
                       input logic ovf, input logic [3:0] cnt, input logic ret);
        vec_t x;
        x.en = en; x.val = val; x.lcrdv = lcrdv; x.txn = txn;
        x.act = act; x.rdy = rdy; x.v = v; x.pend = pend;
        x.ovf = ovf; x.cnt = cnt; x.ret = ret;
        vecs.push_back(x);
    endtask

    task automatic step(input logic en, input logic val, input logic lcrdv, input logic [7:0] txn);
        bus.link_en        = en;
        bus.txrsp_in_valid = val;
        bus.TXRSPLCRDV     = lcrdv;
        bus.txrsp_in       = mk_data(txn);
        @(posedge clk);
        #1;
    endtask

    // FLITV in a cycle must follow PEND in the previous cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (bus.TXRSPFLITV === 1'b1) begin
                checks++;
                if (prev_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_before_flitv got %b want 1 at %0t", prev_pend, $time);
                end
            end
            prev_pend = bus.TXRSPFLITPEND;
        end
    end

    initial begin
        int   rets;
        int   leaked;
        logic done;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.link_en        = 1'b0;
        bus.txrsp_in_valid = 1'b0;
        bus.TXRSPLCRDV     = 1'b0;
        bus.txrsp_in       = '0;

        //   en val lcrd txn     act rdy v pend ovf cnt ret
        add(1, 0, 0, 8'h00,  1, 0, 0, 1, 0, 4'd0, 0);
        add(1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 4'd1, 0);
        add(1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 4'd2, 0);
        add(1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 4'd3, 0);
        add(1, 1, 0, 8'h10,  1, 1, 1, 1, 0, 4'd2, 0);
        add(1, 1, 0, 8'h11,  1, 1, 1, 1, 0, 4'd1, 0);
        add(1, 1, 0, 8'h12,  1, 0, 1, 1, 0, 4'd0, 0);
        add(1, 1, 0, 8'h13,  1, 0, 0, 1, 0, 4'd0, 0);
        add(1, 0, 1, 8'h00,  1, 1, 0, 1, 0, 4'd1, 0);
        add(1, 1, 1, 8'h20,  1, 1, 1, 1, 0, 4'd1, 0);
        add(1, 1, 0, 8'h21,  1, 0, 1, 1, 0, 4'd0, 0);
        for (int unsigned i = 0; i < 16; i++) begin
            add(1, 0, 1, 8'h00, 1, 1, 0, 1, (i == 15), (i < 15) ? 4'(i + 1) : 4'd15, 0);
        end
        add(1, 0, 0, 8'h00,  1, 1, 0, 1, 1, 4'd15, 0);
        for (int unsigned k = 0; k < 11; k++) begin
            add(1, 1, 0, 8'(8'h30 + k), 1, 1, 1, 1, 1, 4'(14 - k), 0);
        end
        add(0, 0, 0, 8'h00,  0, 0, 0, 1, 1, 4'd4, 0);
        add(1, 1, 0, 8'h00,  0, 0, 1, 1, 1, 4'd3, 1);
        add(1, 1, 0, 8'h00,  0, 0, 1, 1, 1, 4'd2, 1);
        add(1, 0, 0, 8'h00,  0, 0, 1, 1, 1, 4'd1, 1);
        add(1, 0, 0, 8'h00,  0, 0, 1, 1, 1, 4'd0, 1);
        add(0, 0, 0, 8'h00,  0, 0, 0, 0, 1, 4'd0, 0);

        #1;
        chk("rst_flitv", 64'(bus.TXRSPFLITV), 64'd0);
        chk("rst_pend",  64'(bus.TXRSPFLITPEND), 64'd0);
        chk("rst_cnt",   64'(bus.lcrd_cnt), 64'd0);
        chk("rst_act",   64'(bus.link_active), 64'd0);
        chk("rst_rdy",   64'(bus.txrsp_in_ready), 64'd0);
        chk("rst_ovf",   64'(bus.lcrd_overflow), 64'd0);
        chk("rst_flit",  64'(bus.TXRSPFLIT), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].val, vecs[i].lcrdv, vecs[i].txn);
            chk($sformatf("v%0d_act", i),  64'(bus.link_active),    64'(vecs[i].act));
            chk($sformatf("v%0d_rdy", i),  64'(bus.txrsp_in_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_flitv", i), 64'(bus.TXRSPFLITV),    64'(vecs[i].v));
            chk($sformatf("v%0d_pend", i), 64'(bus.TXRSPFLITPEND),  64'(vecs[i].pend));
            chk($sformatf("v%0d_ovf", i),  64'(bus.lcrd_overflow),  64'(vecs[i].ovf));
            chk($sformatf("v%0d_cnt", i),  64'(bus.lcrd_cnt),       64'(vecs[i].cnt));
            if (vecs[i].v) begin
                chk($sformatf("v%0d_flit", i), 64'(bus.TXRSPFLIT),
                    vecs[i].ret ? 64'(mk_ret()) : 64'(mk_data(vecs[i].txn)));
            end
        end

        // Deactivation with a credit granted during DEACT: five returns expected.
        step(1, 0, 0, 8'h00);
        for (int unsigned k = 0; k < 4; k++) step(1, 0, 1, 8'h00);
        chk("var_cnt4", 64'(bus.lcrd_cnt), 64'd4);
        step(0, 0, 0, 8'h00);
        chk("var_act", 64'(bus.link_active), 64'd0);
        chk("var_rdy", 64'(bus.txrsp_in_ready), 64'd0);
        rets = 0;
        done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(0, 0, (k == 0), 8'h00);
            if (bus.TXRSPFLITV) begin
                rets++;
                chk("var_ret_flit", 64'(bus.TXRSPFLIT), 64'(mk_ret()));
            end
            if (!bus.TXRSPFLITPEND) begin
                done = 1'b1;
                break;
            end
        end
        chk("var_reached_stop", 64'(done), 64'd1);
        chk("var_returns", 64'(rets), 64'd5);
        chk("var_cnt0", 64'(bus.lcrd_cnt), 64'd0);

        // Reset while holding credits and with a flit on the wire.
        step(1, 0, 0, 8'h00);
        for (int unsigned k = 0; k < 6; k++) step(1, 0, 1, 8'h00);
        step(1, 1, 0, 8'h55);
        chk("mid_flitv", 64'(bus.TXRSPFLITV), 64'd1);
        chk("mid_cnt5",  64'(bus.lcrd_cnt), 64'd5);
        #2;
        rst_n = 1'b0;
        bus.txrsp_in_valid = 1'b0;
        bus.link_en = 1'b0;
        #1;
        chk("arst_flitv", 64'(bus.TXRSPFLITV), 64'd0);
        chk("arst_pend",  64'(bus.TXRSPFLITPEND), 64'd0);
        chk("arst_cnt",   64'(bus.lcrd_cnt), 64'd0);
        chk("arst_act",   64'(bus.link_active), 64'd0);
        chk("arst_ovf",   64'(bus.lcrd_overflow), 64'd0);
        chk("arst_flit",  64'(bus.TXRSPFLIT), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        leaked = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 8'h00);
            if (bus.TXRSPFLITV) leaked++;
        end
        chk("post_rst_returns", 64'(leaked), 64'd0);
        chk("post_rst_pend", 64'(bus.TXRSPFLITPEND), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
